// File: rtl/brq_sched.sv
// brq_sched -- bus request scheduler.
//
// Requests arrive on NREQ channels, and a round-robin arbiter admits one per cycle
// into an arrival-ordered queue. Entry 0 is the oldest entry (the head). The queue
// presents its oldest entry whose destination is free. The head may be bypassed at
// most STARVE times in a row. After that, only the head can be presented.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   req_data   per-channel {src, dest} word; channel i at [i*2*IDW +: 2*IDW]
//   req        per-channel request valid, held until acked
//   dest_free  bit d set when destination d can accept a transfer
//   pull       bus consumes the presented entry this cycle
//   ack        one-hot enqueue grant (combinational)
//   req_ready  an entry is presented on send_out/dest_out
//   send_out   src field of the presented entry (0 when none)
//   dest_out   dest field of the presented entry (0 when none)
//   count      number of valid queue entries
//   full       count == DEPTH
module brq_sched #(
  parameter int NREQ   = 11,
  parameter int DEPTH  = 11,
  parameter int IDW    = 4,
  parameter int STARVE = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [NREQ*2*IDW-1:0]      req_data,
  input  logic [NREQ-1:0]            req,
  input  logic [2**IDW-1:0]          dest_free,
  input  logic                       pull,
  output logic [NREQ-1:0]            ack,
  output logic                       req_ready,
  output logic [IDW-1:0]             send_out,
  output logic [IDW-1:0]             dest_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW   = $clog2(STARVE + 1);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Control state (reset) and entry payload (not reset, qualified by vld_q)
  logic [DEPTH-1:0] vld_q, vld_n;
  logic [IDW-1:0]   src_q [DEPTH];
  logic [IDW-1:0]   dst_q [DEPTH];
  logic [IDW-1:0]   src_n [DEPTH];
  logic [IDW-1:0]   dst_n [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [SW-1:0]    skip_q, skip_n;
  logic [PW-1:0]    rr_q;

  logic [SELW-1:0]  sel;
  logic             has_sel;
  logic             disp;
  logic             gnt_vld;
  logic [PW-1:0]    gnt_idx;
  logic [SELW-1:0]  wpos;
  logic             starved;

  assign count   = cnt_q;
  assign full    = (cnt_q == CW'(DEPTH));
  assign starved = (skip_q == SW'(STARVE));

  // Presentation: the oldest eligible entry. Once the head is starved, only the
  // head may be presented, and only if its destination is free.
  always_comb begin
    sel     = '0;
    has_sel = 1'b0;
    if (starved) begin
      has_sel = vld_q[0] & dest_free[dst_q[0]];
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (vld_q[i] && dest_free[dst_q[i]]) begin
          sel     = SELW'(i);
          has_sel = 1'b1;
        end
      end
    end
  end

  assign req_ready = has_sel;
  assign send_out  = has_sel ? src_q[sel] : '0;
  assign dest_out  = has_sel ? dst_q[sel] : '0;
  assign disp      = pull & has_sel;

  // Round-robin enqueue arbiter. The search starts one past the last grant.
  // A full queue may still grant when a dispatch frees a slot this cycle.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    ack     = '0;
    if (clr && (!full || disp)) begin
      for (int k = NREQ; k >= 1; k--) begin
        idx = (int'(rr_q) + k) % NREQ;
        if (req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
    if (gnt_vld) ack[gnt_idx] = 1'b1;
  end

  // Next queue image: compact over the dispatched slot, then append the new entry.
  always_comb begin
    vld_n = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      src_n[i] = src_q[i];
      dst_n[i] = dst_q[i];
    end
    if (disp) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) begin
          vld_n[i] = vld_q[i+1];
          src_n[i] = src_q[i+1];
          dst_n[i] = dst_q[i+1];
        end
      end
      vld_n[DEPTH-1] = 1'b0;
    end
    wpos = SELW'(cnt_q - CW'(disp));
    if (gnt_vld) begin
      vld_n[wpos] = 1'b1;
      src_n[wpos] = req_data[int'(gnt_idx)*2*IDW + IDW +: IDW];
      dst_n[wpos] = req_data[int'(gnt_idx)*2*IDW +: IDW];
    end
    cnt_n = cnt_q + CW'(gnt_vld) - CW'(disp);
  end

  // Starvation counter: a bypass of a valid head increments it (saturating).
  // Serving the head or draining the queue clears it.
  always_comb begin
    skip_n = skip_q;
    if (disp) begin
      if (sel == '0)      skip_n = '0;
      else if (!starved)  skip_n = skip_q + SW'(1);
    end
    if (cnt_n == '0) skip_n = '0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vld_q  <= '0;
      cnt_q  <= '0;
      skip_q <= '0;
      rr_q   <= PW'(NREQ - 1);
    end else begin
      vld_q  <= vld_n;
      cnt_q  <= cnt_n;
      skip_q <= skip_n;
      if (gnt_vld) rr_q <= gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    src_q <= src_n;
    dst_q <= dst_n;
  end

endmodule

// File: tb/tb_brq_sched.sv
// tb_brq_sched -- directed bench for brq_sched with default parameters.
// Stimulus pushes the expected {src,dest} of each dispatch into a scoreboard.
// A monitor pops and compares it whenever the bus pulls a presented entry.
module tb_brq_sched;

  localparam int NREQ = 11;
  localparam int DEPTH = 11;
  localparam int IDW = 4;

  logic                  clk = 1'b0;
  logic                  clr;
  logic [NREQ*2*IDW-1:0] req_data;
  logic [NREQ-1:0]       req;
  logic [2**IDW-1:0]     dest_free;
  logic                  pull;
  logic [NREQ-1:0]       ack;
  logic                  req_ready;
  logic [IDW-1:0]        send_out;
  logic [IDW-1:0]        dest_out;
  logic [3:0]            count;
  logic                  full;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  brq_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .IDW(IDW), .STARVE(8)) dut (
    .clk(clk), .clr(clr), .req_data(req_data), .req(req), .dest_free(dest_free),
    .pull(pull), .ack(ack), .req_ready(req_ready), .send_out(send_out),
    .dest_out(dest_out), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every dispatch must match the next expected entry.
  always @(negedge clk) begin
    logic [7:0] e;
    if (clr && pull && req_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL dispatch_unexpected: got src=%0d dest=%0d expected none",
                 send_out, dest_out);
      end else begin
        e = sb.pop_front();
        if ({send_out, dest_out} !== e) begin
          n_bad++;
          $display("FAIL dispatch: got src=%0d dest=%0d expected src=%0d dest=%0d",
                   send_out, dest_out, e[7:4], e[3:0]);
        end
      end
    end
  end

  task automatic set_word(input int ch, input int s, input int d);
    logic [7:0] w;
    w = {4'(s), 4'(d)};
    req_data[ch*2*IDW +: 2*IDW] = w;
  endtask

  // Enqueue one entry on a single channel; returns at posedge+1 with req dropped.
  task automatic enq(input int ch, input int s, input int d);
    int got;
    @(posedge clk); #1;
    set_word(ch, s, d);
    req[ch] = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && got == 0; t++) begin
      @(negedge clk);
      if (ack[ch]) got = 1;
    end
    chk("enq_ack", got, 1);
    @(posedge clk); #1;
    req[ch] = 1'b0;
  endtask

  task automatic wait_count(input string name, input int c, input int budget);
    int ok;
    ok = 0;
    for (int t = 0; t < budget && ok == 0; t++) begin
      @(negedge clk);
      if (count == 4'(c)) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    clr = 1'b0;
    req = '1;
    req_data = '0;
    dest_free = '1;
    pull = 1'b0;
    for (int i = 0; i < NREQ; i++) set_word(i, i, i);

    // Reset state, with every request held
    #12;
    chk("rst_ack", int'(ack), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ready", int'(req_ready), 0);

    // Fill: all channels requesting, grants 0..10 in consecutive cycles
    @(posedge clk); #1;
    clr = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      @(negedge clk);
      chk($sformatf("fill_ack%0d", k), int'(ack), 1 << k);
    end
    @(negedge clk);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 11);
    chk("fill_ack_idle", int'(ack), 0);

    // Full queue, dispatch and enqueue on channel 5 in the same cycle
    @(posedge clk); #1;
    req = '0;
    set_word(5, 12, 13);
    req[5] = 1'b1;
    for (int i = 0; i < NREQ; i++) sb.push_back({4'(i), 4'(i)});
    sb.push_back({4'd12, 4'd13});
    pull = 1'b1;
    @(negedge clk);
    chk("full_bypass_ack", int'(ack), 1 << 5);
    @(posedge clk); #1;
    req[5] = 1'b0;
    @(negedge clk);
    chk("full_bypass_count", int'(count), 11);
    wait_count("drain_fill", 0, 30);
    chk("empty_ready", int'(req_ready), 0);
    @(negedge clk);
    chk("empty_pull_count", int'(count), 0);
    chk("empty_pull_ready", int'(req_ready), 0);
    chk("empty_pull_skip", int'(dut.skip_q), 0);
    @(posedge clk); #1;
    pull = 1'b0;
    chk("sb_drained1", sb.size(), 0);

    // Bypass of a busy head by a younger eligible entry
    enq(2, 1, 9);
    enq(3, 4, 3);
    dest_free[9] = 1'b0;
    sb.push_back({4'd4, 4'd3});
    pull = 1'b1;
    @(negedge clk);
    chk("bypass_ready", int'(req_ready), 1);
    chk("bypass_src", int'(send_out), 4);
    chk("bypass_dest", int'(dest_out), 3);
    @(posedge clk); #1;
    pull = 1'b0;
    @(negedge clk);
    chk("bypass_count", int'(count), 1);
    chk("bypass_skip", int'(dut.skip_q), 1);
    chk("bypass_head_blocked", int'(req_ready), 0);

    // Starvation: 7 more bypasses reach STARVE, then the head blocks everything
    for (int j = 0; j < 9; j++) enq(j, j + 2, j);
    chk("starve_fill_count", int'(count), 10);
    for (int j = 0; j < 7; j++) sb.push_back({4'(j + 2), 4'(j)});
    @(posedge clk); #1;
    pull = 1'b1;
    wait_count("starve_reach", 3, 20);
    chk("starve_ready", int'(req_ready), 0);
    chk("starve_skip", int'(dut.skip_q), 8);
    chk("starve_src_zero", int'(send_out), 0);
    @(posedge clk); #1;
    sb.push_back({4'd1, 4'd9});
    sb.push_back({4'd9, 4'd7});
    sb.push_back({4'd10, 4'd8});
    dest_free[9] = 1'b1;
    @(negedge clk);
    chk("starve_head_src", int'(send_out), 1);
    chk("starve_head_dest", int'(dest_out), 9);
    @(negedge clk);
    chk("starve_clear_skip", int'(dut.skip_q), 0);
    chk("starve_clear_count", int'(count), 2);
    wait_count("drain_starve", 0, 10);
    @(posedge clk); #1;
    pull = 1'b0;
    chk("sb_drained2", sb.size(), 0);

    // Asynchronous reset mid-operation, then re-arbitration of a held request
    for (int j = 0; j < 6; j++) enq(j, j, j + 1);
    @(negedge clk);
    chk("pre_reset_count", int'(count), 6);
    @(posedge clk); #2;
    clr = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_ready", int'(req_ready), 0);
    chk("async_src", int'(send_out), 0);
    chk("async_dest", int'(dest_out), 0);
    chk("async_full", int'(full), 0);
    set_word(7, 14, 15);
    req[7] = 1'b1;
    #1;
    chk("async_ack", int'(ack), 0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    chk("rearb_ack", int'(ack), 1 << 7);
    @(posedge clk); #1;
    req[7] = 1'b0;
    @(negedge clk);
    chk("rearb_count", int'(count), 1);
    @(posedge clk); #1;
    sb.push_back({4'd14, 4'd15});
    pull = 1'b1;
    wait_count("drain_rearb", 0, 10);
    @(posedge clk); #1;
    pull = 1'b0;
    chk("sb_drained3", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
